// File: rtl/vending_machine_if.sv
// Coin-strobe and dispense/change bundle between the coin acceptor and the
// vending controller.
interface vending_machine_if;
  logic nickel;
  logic dime;
  logic quarter;
  logic dispense;
  logic change;

  modport master (
    output nickel, dime, quarter,
    input  dispense, change
  );

  modport slave (
    input  nickel, dime, quarter,
    output dispense, change
  );
endinterface

// File: rtl/vending_machine.sv
// Single-item (15 cent) vending controller: accumulates nickel/dime/quarter
// credit, pulses dispense at price, then returns overpayment one nickel per cycle.
module vending_machine (
  input logic              clk,
  input logic              rst_n,
  vending_machine_if.slave vm
);

  typedef enum logic [1:0] {
    C0  = 2'd0,
    C5  = 2'd1,
    C10 = 2'd2
  } credit_e;

  credit_e    r_credit;
  logic [2:0] r_owe;
  logic       r_dispense;
  logic       r_change;

  credit_e    w_credit_next;
  logic [2:0] w_owe_next;
  logic       w_dispense_next;
  logic       w_change_next;
  logic [5:0] w_coin_val;
  logic [5:0] w_credit_val;
  logic [5:0] w_total;
  logic [2:0] w_nickels_back;

  // Simultaneous strobes are a rejected coin, worth nothing.
  always_comb begin
    case ({vm.nickel, vm.dime, vm.quarter})
      3'b100:  w_coin_val = 6'd5;
      3'b010:  w_coin_val = 6'd10;
      3'b001:  w_coin_val = 6'd25;
      default: w_coin_val = 6'd0;
    endcase
  end

  always_comb begin
    case (r_credit)
      C5:      w_credit_val = 6'd5;
      C10:     w_credit_val = 6'd10;
      default: w_credit_val = 6'd0;
    endcase
  end

  assign w_total = w_credit_val + w_coin_val;

  always_comb begin
    case (w_total)
      6'd20:   w_nickels_back = 3'd1;
      6'd25:   w_nickels_back = 3'd2;
      6'd30:   w_nickels_back = 3'd3;
      6'd35:   w_nickels_back = 3'd4;
      default: w_nickels_back = 3'd0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_credit_next   = r_credit;
    w_owe_next      = r_owe;
    w_dispense_next = 1'b0;
    w_change_next   = 1'b0;

    if (r_owe != 3'd0) begin
      // Returning change: coins arriving now are lost.
      w_change_next = 1'b1;
      w_owe_next    = r_owe - 3'd1;
      w_credit_next = C0;
    end else if (w_total < 6'd15) begin
      case (w_total)
        6'd5:    w_credit_next = C5;
        6'd10:   w_credit_next = C10;
        default: w_credit_next = C0;
      endcase
    end else begin
      w_dispense_next = 1'b1;
      w_credit_next   = C0;
      if (w_nickels_back != 3'd0) begin
        // First change pulse rides with dispense, so one fewer is still owed.
        w_change_next = 1'b1;
        w_owe_next    = w_nickels_back - 3'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit   <= C0;
      r_owe      <= 3'd0;
      r_dispense <= 1'b0;
      r_change   <= 1'b0;
    end else begin
      r_credit   <= w_credit_next;
      r_owe      <= w_owe_next;
      r_dispense <= w_dispense_next;
      r_change   <= w_change_next;
    end
  end

  assign vm.dispense = r_dispense;
  assign vm.change   = r_change;

endmodule

// File: tb/tb_vending_machine.sv
// Directed test of vending_machine: each vector is {nickel,dime,quarter,
// expected dispense, expected change} for one sampled clock edge.
module tb_vending_machine;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vending_machine_if vm ();

  vending_machine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vm    (vm.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply coins for one edge and return the outputs registered on that edge.
  task automatic drive_edge(input logic [2:0] coins, output logic d, output logic c);
    @(negedge clk);
    {vm.nickel, vm.dime, vm.quarter} = coins;
    @(posedge clk);
    #1;
    d = vm.dispense;
    c = vm.change;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {vm.nickel, vm.dime, vm.quarter} = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({vm.dispense, vm.change} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: dispense/change=%b%b expected 00", vm.dispense, vm.change);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({vm.dispense, vm.change} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: dispense/change=%b%b expected 00", vm.dispense, vm.change);
    end
  endtask

  task automatic test_basic();
    logic [4:0] v [4] = '{5'b100_00, 5'b010_10, 5'b010_00, 5'b000_00};
    logic d, c;
    for (int i = 0; i < 4; i++) begin
      drive_edge(v[i][4:2], d, c);
      n_checks++;
      if ({d, c} !== v[i][1:0]) begin
        n_fail++;
        $display("FAIL basic[%0d]: dispense/change=%b%b expected %b", i, d, c, v[i][1:0]);
      end
    end
  endtask

  // Credit 10 left by test_basic; a quarter owes four nickels.
  task automatic test_max_change();
    logic [4:0] v [7] = '{5'b001_11, 5'b000_01, 5'b000_01, 5'b000_01,
                          5'b000_00, 5'b010_00, 5'b100_10};
    logic d, c;
    for (int i = 0; i < 7; i++) begin
      drive_edge(v[i][4:2], d, c);
      n_checks++;
      if ({d, c} !== v[i][1:0]) begin
        n_fail++;
        $display("FAIL max_change[%0d]: dispense/change=%b%b expected %b", i, d, c, v[i][1:0]);
      end
    end
  endtask

  task automatic test_quarter_from_zero();
    logic [4:0] v [3] = '{5'b001_11, 5'b000_01, 5'b000_00};
    logic d, c;
    for (int i = 0; i < 3; i++) begin
      drive_edge(v[i][4:2], d, c);
      n_checks++;
      if ({d, c} !== v[i][1:0]) begin
        n_fail++;
        $display("FAIL quarter_zero[%0d]: dispense/change=%b%b expected %b", i, d, c, v[i][1:0]);
      end
    end
  endtask

  // Multi-coin strobes must leave credit at 5, so a dime dispenses with no change.
  task automatic test_reject();
    logic [4:0] v [6] = '{5'b100_00, 5'b011_00, 5'b110_00, 5'b111_00,
                          5'b000_00, 5'b010_10};
    logic d, c;
    for (int i = 0; i < 6; i++) begin
      drive_edge(v[i][4:2], d, c);
      n_checks++;
      if ({d, c} !== v[i][1:0]) begin
        n_fail++;
        $display("FAIL reject[%0d]: dispense/change=%b%b expected %b", i, d, c, v[i][1:0]);
      end
    end
  endtask

  // Nickels during change are lost; the one on the edge ending the last pulse counts.
  task automatic test_coins_during_change();
    logic [4:0] v [7] = '{5'b010_00, 5'b001_11, 5'b100_01, 5'b100_01,
                          5'b100_01, 5'b100_00, 5'b010_10};
    logic d, c;
    for (int i = 0; i < 7; i++) begin
      drive_edge(v[i][4:2], d, c);
      n_checks++;
      if ({d, c} !== v[i][1:0]) begin
        n_fail++;
        $display("FAIL coins_during_change[%0d]: dispense/change=%b%b expected %b", i, d, c, v[i][1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_change();
    logic [4:0] pre  [3] = '{5'b010_00, 5'b001_11, 5'b000_01};
    logic [4:0] post [4] = '{5'b010_00, 5'b000_00, 5'b000_00, 5'b100_10};
    logic d, c;
    for (int i = 0; i < 3; i++) begin
      drive_edge(pre[i][4:2], d, c);
      n_checks++;
      if ({d, c} !== pre[i][1:0]) begin
        n_fail++;
        $display("FAIL reset_mid_pre[%0d]: dispense/change=%b%b expected %b", i, d, c, pre[i][1:0]);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vm.dispense, vm.change} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_async: dispense/change=%b%b expected 00", vm.dispense, vm.change);
    end
    @(negedge clk);
    {vm.nickel, vm.dime, vm.quarter} = 3'b000;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_edge(post[i][4:2], d, c);
      n_checks++;
      if ({d, c} !== post[i][1:0]) begin
        n_fail++;
        $display("FAIL reset_mid_post[%0d]: dispense/change=%b%b expected %b", i, d, c, post[i][1:0]);
      end
    end
  endtask

  // Held nickel counts per edge, then purchases follow each other with no gap.
  task automatic test_back_to_back();
    logic [4:0] v [8] = '{5'b100_00, 5'b100_00, 5'b100_10, 5'b010_00,
                          5'b100_10, 5'b001_11, 5'b000_01, 5'b000_00};
    logic d, c;
    for (int i = 0; i < 8; i++) begin
      drive_edge(v[i][4:2], d, c);
      n_checks++;
      if ({d, c} !== v[i][1:0]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: dispense/change=%b%b expected %b", i, d, c, v[i][1:0]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_max_change();
    test_quarter_from_zero();
    test_reject();
    test_coins_during_change();
    test_reset_mid_change();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
